// File: rtl/clarke_arb.sv
// Round-robin sequencer sharing one Clarke transform unit between N_REQ
// current-sample requesters. Operands are latched on grant, the unit gets a
// one-cycle start, and alpha/beta are captured LAT cycles later into a
// per-requester result slot that is drained through its own handshake.
//
// Handshakes: a transfer happens on the rising clk edge where valid and ready
// are both 1. On the request side req_ready is combinational from the FSM
// state and req_valid. On the result side res_valid is registered, its data
// stays stable while it is held, and it clears on the edge where res_ready is 1.
module clarke_arb #(
    parameter int D_WIDTH = 18,
    parameter int N_REQ   = 2,
    parameter int LAT     = 1
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*D_WIDTH-1:0]   req_a,
    input  logic [N_REQ*D_WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]           res_valid,
    input  logic [N_REQ-1:0]           res_ready,
    output logic [N_REQ*D_WIDTH-1:0]   res_alpha,
    output logic [N_REQ*D_WIDTH-1:0]   res_beta,
    output logic                       ck_start,
    output logic [D_WIDTH-1:0]         ck_a,
    output logic [D_WIDTH-1:0]         ck_b,
    input  logic [D_WIDTH-1:0]         ck_alpha,
    input  logic [D_WIDTH-1:0]         ck_beta,
    output logic                       busy
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [ID_W-1:0]          rr_q, rr_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [D_WIDTH-1:0]       op_a_q, op_a_d;
    logic [D_WIDTH-1:0]       op_b_q, op_b_d;
    logic [N_REQ-1:0]         res_valid_q, res_valid_d;
    logic [N_REQ*D_WIDTH-1:0] res_alpha_q, res_alpha_d;
    logic [N_REQ*D_WIDTH-1:0] res_beta_q, res_beta_d;

    logic [N_REQ-1:0]         elig;
    logic                     gnt_found;
    logic [ID_W-1:0]          gnt_id;
    logic [ID_W:0]            scan_sum;
    logic [ID_W-1:0]          scan_idx;

    // Round-robin search: first eligible index at or after the pointer, wrapping.
    // A requester whose result slot is still full is not eligible.
    always_comb begin
        elig      = req_valid & ~res_valid_q;
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!gnt_found && elig[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
        end
    end

    // Accept only the granted requester, and only while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Sequencer next state: grant -> issue start -> count down latency -> capture.
    // Result slots drain independently of the sequencer state.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_valid_d = res_valid_q & ~res_ready;
        res_alpha_d = res_alpha_q;
        res_beta_d  = res_beta_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    op_a_d  = req_a[int'(gnt_id)*D_WIDTH +: D_WIDTH];
                    op_b_d  = req_b[int'(gnt_id)*D_WIDTH +: D_WIDTH];
                    id_d    = gnt_id;
                    rr_d    = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(LAT-1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // The slot was empty at grant time, so no drain can race this capture.
                    res_alpha_d[int'(id_q)*D_WIDTH +: D_WIDTH] = ck_alpha;
                    res_beta_d[int'(id_q)*D_WIDTH +: D_WIDTH]  = ck_beta;
                    res_valid_d[id_q] = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation and all held results.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_valid_q <= '0;
            res_alpha_q <= '0;
            res_beta_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_valid_q <= res_valid_d;
            res_alpha_q <= res_alpha_d;
            res_beta_q  <= res_beta_d;
        end
    end

    // The unit's done level is sticky, so it is not used; the latency counter sequences.
    assign ck_start  = (state_q == S_ISSUE);
    assign ck_a      = op_a_q;
    assign ck_b      = op_b_q;
    assign busy      = (state_q != S_IDLE);
    assign res_valid = res_valid_q;
    assign res_alpha = res_alpha_q;
    assign res_beta  = res_beta_q;

endmodule

// File: tb/tb_clarke_arb.sv
// Bench for clarke_arb: one instance with LAT=1 and one with LAT=3, each
// attached to a behavioural Clarke unit. Expected results are pushed when a
// request is accepted; a monitor pops and compares as results are drained.
module tb_clarke_arb;

    localparam int DW = 18;
    localparam logic [DW-1:0] BETA_Q = 18'h024F3;  // (a + 2b) = 16384 -> 9459
    localparam logic [DW-1:0] JUNK   = 18'h2AAAA;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstb;
    logic rstb3;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]    req_valid1, req_ready1, res_valid1, res_ready1;
    logic [2*DW-1:0] req_a1, req_b1, res_alpha1, res_beta1;
    logic          ck_start1, busy1;
    logic [DW-1:0] ck_a1, ck_b1;
    logic [DW-1:0] ck_alpha1 = '0, ck_beta1 = '0;

    logic [1:0]    req_valid3, req_ready3, res_valid3, res_ready3;
    logic [2*DW-1:0] req_a3, req_b3, res_alpha3, res_beta3;
    logic          ck_start3, busy3;
    logic [DW-1:0] ck_a3, ck_b3;
    logic [DW-1:0] ck_alpha3 = '0, ck_beta3 = '0;

    clarke_arb #(.D_WIDTH(DW), .N_REQ(2), .LAT(1)) u1 (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_a(req_a1), .req_b(req_b1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_alpha(res_alpha1), .res_beta(res_beta1),
        .ck_start(ck_start1), .ck_a(ck_a1), .ck_b(ck_b1),
        .ck_alpha(ck_alpha1), .ck_beta(ck_beta1), .busy(busy1)
    );

    clarke_arb #(.D_WIDTH(DW), .N_REQ(2), .LAT(3)) u3 (
        .clk(clk), .rstb(rstb3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_a(req_a3), .req_b(req_b3),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_alpha(res_alpha3), .res_beta(res_beta3),
        .ck_start(ck_start3), .ck_a(ck_a3), .ck_b(ck_b3),
        .ck_alpha(ck_alpha3), .ck_beta(ck_beta3), .busy(busy3)
    );

    // ---------------- shared Clarke unit models ----------------
    function automatic logic [DW-1:0] beta_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = (longint'($signed(a)) + 2 * longint'($signed(b))) * 18918;
        return DW'(s >>> 15);
    endfunction

    // LAT=1: outputs registered one clk after start, then held.
    always @(posedge clk) begin
        if (ck_start1) begin
            ck_alpha1 <= ck_a1;
            ck_beta1  <= beta_f(ck_a1, ck_b1);
        end
    end

    // LAT=3: outputs show junk while computing, valid three clks after start.
    logic [DW-1:0] pa3 = '0, pb3 = '0;
    int cnt3 = 0;
    always @(posedge clk) begin
        if (ck_start3) begin
            pa3       <= ck_a3;
            pb3       <= beta_f(ck_a3, ck_b3);
            cnt3      <= 2;
            ck_alpha3 <= JUNK;
            ck_beta3  <= JUNK;
        end else if (cnt3 > 0) begin
            cnt3 <= cnt3 - 1;
            if (cnt3 == 1) begin
                ck_alpha3 <= pa3;
                ck_beta3  <= pb3;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Slots 0,1 belong to u1; slots 2,3 belong to u3. Entry = {alpha, beta}.
    logic [2*DW-1:0] exp_q [4][$];
    logic [3:0]      mon_v, mon_r;
    logic [2*DW-1:0] mon_d [4];
    logic [2*DW-1:0] held_d [4];
    bit   [3:0]      held_v = '0;
    bit              prev_start1 = 1'b0;
    int              start_cnt1 = 0;

    assign mon_v = {res_valid3, res_valid1};
    assign mon_r = {res_ready3, res_ready1};
    always_comb begin
        mon_d[0] = {res_alpha1[DW-1:0],  res_beta1[DW-1:0]};
        mon_d[1] = {res_alpha1[2*DW-1:DW], res_beta1[2*DW-1:DW]};
        mon_d[2] = {res_alpha3[DW-1:0],  res_beta3[DW-1:0]};
        mon_d[3] = {res_alpha3[2*DW-1:DW], res_beta3[2*DW-1:DW]};
    end

    always @(negedge clk) begin
        if (ck_start1) begin
            start_cnt1++;
            chk("no_adjacent_start", 64'(prev_start1), 64'd0);
        end
        prev_start1 = ck_start1;
        for (int i = 0; i < 4; i++) begin
            if (mon_v[i]) begin
                if (held_v[i]) chk($sformatf("result_stable_%0d", i), mon_d[i], held_d[i]);
                held_d[i] = mon_d[i];
                held_v[i] = 1'b1;
                if (mon_r[i]) begin
                    held_v[i] = 1'b0;
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_result_%0d: got %0h expected none", i, mon_d[i]);
                    end else begin
                        chk($sformatf("result_%0d", i), mon_d[i], exp_q[i].pop_front());
                    end
                end
            end else begin
                held_v[i] = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] va [6] = '{18'h04000, 18'h02000, 18'h00000, 18'h06000, 18'h3C000, 18'h00800};
    logic [DW-1:0] vb [6] = '{18'h00000, 18'h01000, 18'h02000, 18'h3F000, 18'h04000, 18'h01C00};

    initial begin
        int s0, grants, last_g, last_cyc, g;
        int nxt [2];
        rstb = 1'b0; rstb3 = 1'b0;
        req_valid1 = '0; res_ready1 = '0; req_a1 = '0; req_b1 = '0;
        req_valid3 = '0; res_ready3 = '0; req_a3 = '0; req_b3 = '0;
        repeat (3) tick;

        // Reset state
        chk("rst_req_ready", req_ready1, 0);
        chk("rst_res_valid", res_valid1, 0);
        chk("rst_res_alpha", res_alpha1, 0);
        chk("rst_res_beta", res_beta1, 0);
        chk("rst_ck_start", ck_start1, 0);
        chk("rst_ck_a", ck_a1, 0);
        chk("rst_ck_b", ck_b1, 0);
        chk("rst_busy", busy1, 0);
        rstb = 1'b1; rstb3 = 1'b1;

        // Single op: handshake T, start T+1, result valid only in T+3
        tick;
        res_ready1 = 2'b11;
        req_a1[DW-1:0] = 18'h04000; req_b1[DW-1:0] = 18'h00000; req_valid1 = 2'b01;
        s0 = start_cnt1;
        exp_q[0].push_back({18'h04000, BETA_Q});
        @(negedge clk);
        chk("t1_req_ready", req_ready1, 2'b01);
        chk("t1_no_start_T", ck_start1, 0);
        tick; req_valid1 = 2'b00;
        @(negedge clk);
        chk("t1_start_T1", ck_start1, 1);
        chk("t1_ck_a", ck_a1, 18'h04000);
        chk("t1_ck_b", ck_b1, 18'h00000);
        chk("t1_busy", busy1, 1);
        tick; @(negedge clk);
        chk("t1_start_low_T2", ck_start1, 0);
        chk("t1_ck_a_hold", ck_a1, 18'h04000);
        chk("t1_res_valid_T2", res_valid1, 2'b00);
        tick; @(negedge clk);
        chk("t1_res_valid_T3", res_valid1, 2'b01);
        tick; @(negedge clk);
        chk("t1_res_valid_T4", res_valid1, 2'b00);
        chk("t1_idle", busy1, 0);
        chk("t1_one_start", 64'(start_cnt1 - s0), 64'd1);

        // Simultaneous requests from pointer 0
        tick; rstb = 1'b0;
        tick; rstb = 1'b1;
        tick;
        req_valid1 = 2'b11;
        req_a1 = {18'h00000, 18'h04000};
        req_b1 = {18'h02000, 18'h00000};
        exp_q[0].push_back({18'h04000, BETA_Q});
        exp_q[1].push_back({18'h00000, BETA_Q});
        @(negedge clk); chk("t2_grant_ch0", req_ready1, 2'b01);
        tick; req_valid1 = 2'b10;
        @(negedge clk); chk("t2_busy_T1", req_ready1, 2'b00);
        tick; @(negedge clk); chk("t2_busy_T2", req_ready1, 2'b00);
        tick; @(negedge clk); chk("t2_grant_ch1_T3", req_ready1, 2'b10);
        tick; req_valid1 = 2'b00;
        @(negedge clk);
        chk("t2_ch1_start", ck_start1, 1);
        chk("t2_ch1_ck_b", ck_b1, 18'h02000);
        tick; tick; @(negedge clk); chk("t2_ch1_valid", res_valid1, 2'b10);
        tick;

        // Back-pressure on slot 0, negative operands on ch1, pointer back at 0
        tick;
        res_ready1 = 2'b10;
        req_valid1 = 2'b11;
        req_a1 = {18'h3C000, 18'h01000};
        req_b1 = {18'h3C000, 18'h00000};
        exp_q[0].push_back({18'h01000, 18'h0093C});  // 4096*18918>>15 = 2364
        exp_q[1].push_back({18'h3C000, 18'h39127});  // -49152*18918 = -28377*32768 exactly
        @(negedge clk); chk("t3_ptr0_grant_ch0", req_ready1, 2'b01);
        tick; req_valid1 = 2'b10;
        @(negedge clk); chk("t3_busy", req_ready1, 2'b00);
        tick;
        tick;
        req_valid1 = 2'b11;
        req_a1[DW-1:0] = 18'h02000; req_b1[DW-1:0] = 18'h01000;
        exp_q[0].push_back({18'h02000, BETA_Q});
        @(negedge clk);
        chk("t3_slot0_held", res_valid1, 2'b01);
        chk("t3_blocked_grant_ch1", req_ready1, 2'b10);
        tick; req_valid1 = 2'b01;
        @(negedge clk); chk("t3_ch0_blocked_busy", req_ready1, 2'b00);
        tick; tick; @(negedge clk);
        chk("t3_both_valid", res_valid1, 2'b11);
        chk("t3_ch0_blocked_idle", req_ready1, 2'b00);
        tick; res_ready1 = 2'b11;
        @(negedge clk); chk("t3_drain_cycle", req_ready1, 2'b00);
        tick; @(negedge clk);
        chk("t3_freed_grant", req_ready1, 2'b01);
        chk("t3_slots_empty", res_valid1, 2'b00);
        tick; req_valid1 = 2'b00;
        tick; tick; @(negedge clk); chk("t3_ch0_second", res_valid1, 2'b01);
        tick;

        // Streaming: both always valid, consumers always ready
        tick;
        nxt[0] = 0; nxt[1] = 3;
        req_a1 = {va[3], va[0]}; req_b1 = {vb[3], vb[0]};
        req_valid1 = 2'b11;
        grants = 0; last_g = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            @(negedge clk);
            if ((req_valid1 & req_ready1) != 2'b00) begin
                g = req_ready1[1] ? 1 : 0;
                if (grants > 0) begin
                    chk("stream_alternate", 64'(g), 64'(1 - last_g));
                    chk("stream_spacing", 64'(cyc - last_cyc), 64'd3);
                end
                exp_q[g].push_back({va[nxt[g]], BETA_Q});
                nxt[g]++;
                grants++;
                last_g = g; last_cyc = cyc;
                tick;
                if (nxt[g] < 3 * (g + 1)) begin
                    req_a1[g*DW +: DW] = va[nxt[g]];
                    req_b1[g*DW +: DW] = vb[nxt[g]];
                end else begin
                    req_valid1[g] = 1'b0;
                end
            end else begin
                tick;
            end
        end
        chk("stream_grants", 64'(grants), 64'd6);
        req_valid1 = 2'b00;
        repeat (6) tick;

        // LAT=3: reset during WAIT discards the operation
        res_ready3 = 2'b11;
        tick;
        req_a3[DW-1:0] = 18'h04000; req_b3[DW-1:0] = 18'h00000; req_valid3 = 2'b01;
        @(negedge clk); chk("l3_grant", req_ready3, 2'b01);
        tick; req_valid3 = 2'b00;
        @(negedge clk); chk("l3_start", ck_start3, 1);
        tick; @(negedge clk);
        chk("l3_wait_busy", busy3, 1);
        rstb3 = 1'b0;
        #1;
        chk("l3_rst_req_ready", req_ready3, 0);
        chk("l3_rst_res_valid", res_valid3, 0);
        chk("l3_rst_res_alpha", res_alpha3, 0);
        chk("l3_rst_res_beta", res_beta3, 0);
        chk("l3_rst_ck_start", ck_start3, 0);
        chk("l3_rst_ck_a", ck_a3, 0);
        chk("l3_rst_ck_b", ck_b3, 0);
        chk("l3_rst_busy", busy3, 0);
        tick; tick; rstb3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("l3_no_result_after_rst", res_valid3, 2'b00);
            tick;
        end

        // LAT=3: fresh request completes, result valid in T+5 only
        req_a3[2*DW-1:DW] = 18'h00000; req_b3[2*DW-1:DW] = 18'h02000; req_valid3 = 2'b10;
        exp_q[3].push_back({18'h00000, BETA_Q});
        @(negedge clk); chk("l3_fresh_grant", req_ready3, 2'b10);
        tick; req_valid3 = 2'b00;
        @(negedge clk); chk("l3_fresh_start", ck_start3, 1);
        tick; tick; tick; @(negedge clk);
        chk("l3_not_yet_T4", res_valid3, 2'b00);
        tick; @(negedge clk);
        chk("l3_valid_T5", res_valid3, 2'b10);
        tick; tick;

        for (int i = 0; i < 4; i++) chk($sformatf("queue_empty_%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles long.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
